// File: rtl/sub_chunked_seq_if.sv
// Chunk-stream bundle for sub_chunked_seq: start, input a/b handshake, output c handshake and status.
// With SUB_ZERO_FLAG_EN defined the bundle also carries eq.
interface sub_chunked_seq_if #(
    parameter int W = 16
);
    logic         start;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         borrow_out;
    logic         busy;
`ifdef SUB_ZERO_FLAG_EN
    logic         eq;

    modport slave (
        input  start, in_valid, a, b, out_ready,
        output in_ready, c, out_valid, out_last, borrow_out, busy, eq
    );
    modport master (
        output start, in_valid, a, b, out_ready,
        input  in_ready, c, out_valid, out_last, borrow_out, busy, eq
    );
`else
    modport slave (
        input  start, in_valid, a, b, out_ready,
        output in_ready, c, out_valid, out_last, borrow_out, busy
    );
    modport master (
        output start, in_valid, a, b, out_ready,
        input  in_ready, c, out_valid, out_last, borrow_out, busy
    );
`endif
endinterface

// File: rtl/sub_chunked_seq.sv
// Chunk-serial N-bit subtractor c = a - b, least-significant chunk first, borrow chained across beats.
// Optional SUB_ZERO_FLAG_EN adds eq (a == b over all N bits, presented with out_last).
module sub_chunked_seq #(
    parameter int N  = 256,
    parameter int CC = 16
) (
    input  logic             clk,
    input  logic             rst,
    sub_chunked_seq_if.slave bus
);
    localparam int W  = N / CC;
    localparam int CW = (CC > 1) ? $clog2(CC) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CC - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_borrow;
    logic [W-1:0]  r_c;
    logic          r_out_valid;
    logic          r_out_last;
    logic          r_borrow_out;

    logic          w_in_ready;
    logic          w_accept;
    logic          w_xfer;
    logic          w_last;
    logic [W:0]    w_diff;

    // Top bit of the W+1-bit result is the borrow into the next chunk.
    function automatic logic [W:0] sub_chunk(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic bin);
        return {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bin};
    endfunction

    assign w_in_ready = (r_state == RUN) && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_xfer     = r_out_valid && bus.out_ready;
    assign w_last     = (r_cnt == LAST_CNT);
    assign w_diff     = sub_chunk(bus.a, bus.b, r_borrow);

    assign bus.in_ready   = w_in_ready;
    assign bus.c          = r_c;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_last   = r_out_last;
    assign bus.borrow_out = r_borrow_out;
    assign bus.busy       = (r_state != IDLE);

`ifdef SUB_ZERO_FLAG_EN
    logic r_flag;
    assign bus.eq = r_out_last & r_flag;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_borrow     <= 1'b0;
            r_c          <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_borrow_out <= 1'b0;
`ifdef SUB_ZERO_FLAG_EN
            r_flag       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state      <= RUN;
                        r_cnt        <= '0;
                        r_borrow     <= 1'b0;
                        r_borrow_out <= 1'b0;
`ifdef SUB_ZERO_FLAG_EN
                        r_flag       <= 1'b1;
`endif
                    end
                end
                RUN:     if (w_accept && w_last) r_state <= DRAIN;
                DRAIN:   if (w_xfer) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase

            // A new chunk wins over a plain transfer so back-to-back beats keep out_valid high.
            if (w_accept) begin
                r_c         <= w_diff[W-1:0];
                r_borrow    <= w_diff[W];
                r_out_valid <= 1'b1;
                r_out_last  <= w_last;
                r_cnt       <= w_last ? '0 : r_cnt + 1'b1;
                if (w_last) r_borrow_out <= w_diff[W];
`ifdef SUB_ZERO_FLAG_EN
                r_flag      <= r_flag & (w_diff[W-1:0] == '0);
`endif
            end else if (w_xfer) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sub_chunked_seq.sv
// Scoreboard bench for sub_chunked_seq: a 256-bit reference subtraction fills the expected-chunk queue.
module tb_sub_chunked_seq;
    localparam int N  = 256;
    localparam int CC = 16;
    localparam int W  = N / CC;

    typedef struct packed {
        logic [W-1:0] c;
        logic         last;
        logic         bout;
        logic         eq;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    sub_chunked_seq_if #(.W(W)) bus();

    sub_chunked_seq #(.N(N), .CC(CC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic push_op(input logic [N-1:0] A, input logic [N-1:0] B);
        logic [N-1:0] d;
        exp_t e;
        d = A - B;
        for (int k = 0; k < CC; k++) begin
            e.c    = d[k*W +: W];
            e.last = (k == CC - 1);
            e.bout = (A < B);
            e.eq   = (A == B);
            sb.push_back(e);
        end
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        tests++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0 ||
            bus.c !== '0 || bus.out_last !== 1'b0 || bus.borrow_out !== 1'b0)
            begin fails++; $display("FAIL reset_state: vld=%b busy=%b rdy=%b c=%h last=%b bo=%b, want all 0",
                bus.out_valid, bus.busy, bus.in_ready, bus.c, bus.out_last, bus.borrow_out); end
        rst = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0)
            begin fails++; $display("FAIL idle_after_reset: busy=%b rdy=%b, want 0 0", bus.busy, bus.in_ready); end
    endtask

    task automatic test_patterns();
        logic [N-1:0] A, B;
        exp_t e;
        for (int p = 0; p < 4; p++) begin
            case (p)
                0: begin A = N'(1);             B = '0;       end
                1: begin A = '0;                B = N'(1);    end
                2: begin A = N'(1) << 16;       B = N'(1);    end
                default: begin A = {CC{16'h8000}}; B = {CC{16'h8000}}; end
            endcase
            push_op(A, B);
            if (p == 0) begin
                bus.in_valid = 1'b1; bus.a = A[W-1:0]; bus.b = B[W-1:0];
            end
            do_start();
            if (p == 0) begin
                tests++;
                if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1)
                    begin fails++; $display("FAIL start_cycle_chunk: vld=%b busy=%b, want 0 1", bus.out_valid, bus.busy); end
            end
            for (int k = 0; k < CC; k++) begin
                bus.in_valid = 1'b1; bus.a = A[k*W +: W]; bus.b = B[k*W +: W];
                @(posedge clk); #1;
                e = sb.pop_front();
                tests++;
                if (bus.out_valid !== 1'b1 || bus.c !== e.c || bus.out_last !== e.last)
                    begin fails++; $display("FAIL pat%0d_beat%0d: vld=%b c=%h last=%b, want 1 %h %b",
                        p, k, bus.out_valid, bus.c, bus.out_last, e.c, e.last); end
                if (e.last) begin
                    tests++;
                    if (bus.borrow_out !== e.bout)
                        begin fails++; $display("FAIL pat%0d_borrow: got %b want %b", p, bus.borrow_out, e.bout); end
`ifdef SUB_ZERO_FLAG_EN
                    tests++;
                    if (bus.eq !== e.eq)
                        begin fails++; $display("FAIL pat%0d_eq: got %b want %b", p, bus.eq, e.eq); end
`endif
                end
            end
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
            tests++;
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_last !== 1'b0)
                begin fails++; $display("FAIL pat%0d_drain: vld=%b busy=%b last=%b, want 0 0 0",
                    p, bus.out_valid, bus.busy, bus.out_last); end
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] A, B;
        logic [W-1:0] held;
        exp_t e;
        A = {8{32'h1357_9BDF}};
        B = {8{32'h2468_ACE0}};
        push_op(A, B);
        do_start();
        for (int k = 0; k < CC; k++) begin
            bus.in_valid = 1'b1; bus.a = A[k*W +: W]; bus.b = B[k*W +: W];
            @(posedge clk); #1;
            e = sb.pop_front();
            held = e.c;
            tests++;
            if (bus.out_valid !== 1'b1 || bus.c !== e.c || bus.out_last !== e.last)
                begin fails++; $display("FAIL bp_beat%0d: vld=%b c=%h last=%b, want 1 %h %b",
                    k, bus.out_valid, bus.c, bus.out_last, e.c, e.last); end
            if (e.last) begin
                tests++;
                if (bus.borrow_out !== e.bout)
                    begin fails++; $display("FAIL bp_borrow: got %b want %b", bus.borrow_out, e.bout); end
            end
            if (k == 4) begin
                for (int s = 0; s < 3; s++) begin
                    bus.out_ready = 1'b0;
                    @(posedge clk); #1;
                    tests++;
                    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.c !== held)
                        begin fails++; $display("FAIL bp_stall%0d: rdy=%b vld=%b c=%h, want 0 1 %h",
                            s, bus.in_ready, bus.out_valid, bus.c, held); end
                end
                bus.out_ready = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || sb.size() != 0)
            begin fails++; $display("FAIL bp_drain: busy=%b vld=%b left=%0d, want 0 0 0",
                bus.busy, bus.out_valid, sb.size()); end
    endtask

    task automatic test_reset_abort();
        logic [N-1:0] A, B;
        exp_t e;
        A = {8{32'hDEAD_BEEF}};
        B = {8{32'h0BAD_F00D}};
        push_op(A, B);
        do_start();
        for (int k = 0; k < 8; k++) begin
            bus.in_valid = 1'b1; bus.a = A[k*W +: W]; bus.b = B[k*W +: W];
            @(posedge clk); #1;
            e = sb.pop_front();
            tests++;
            if (bus.c !== e.c)
                begin fails++; $display("FAIL abort_beat%0d: c=%h want %h", k, bus.c, e.c); end
        end
        rst = 1'b0;
        #1;
        tests++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.c !== '0 || bus.in_ready !== 1'b0)
            begin fails++; $display("FAIL abort_state: vld=%b busy=%b c=%h rdy=%b, want 0 0 0 0",
                bus.out_valid, bus.busy, bus.c, bus.in_ready); end
        sb.delete();
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        A = N'(5);
        B = N'(3);
        push_op(A, B);
        do_start();
        for (int k = 0; k < CC; k++) begin
            bus.in_valid = 1'b1; bus.a = A[k*W +: W]; bus.b = B[k*W +: W];
            @(posedge clk); #1;
            e = sb.pop_front();
            tests++;
            if (bus.c !== e.c || bus.out_last !== e.last)
                begin fails++; $display("FAIL post_reset_beat%0d: c=%h last=%b, want %h %b",
                    k, bus.c, bus.out_last, e.c, e.last); end
            if (e.last) begin
                tests++;
                if (bus.borrow_out !== 1'b0)
                    begin fails++; $display("FAIL post_reset_borrow: got %b want 0", bus.borrow_out); end
            end
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] A, B;
        exp_t e;
        for (int op = 0; op < 3; op++) begin
            for (int j = 0; j < N / 32; j++) begin
                A[j*32 +: 32] = $urandom;
                B[j*32 +: 32] = $urandom;
            end
            if (op == 2) B = A;
            push_op(A, B);
            do_start();
            for (int k = 0; k < CC; k++) begin
                bus.in_valid = 1'b1; bus.a = A[k*W +: W]; bus.b = B[k*W +: W];
                bus.start = (k == 3);
                @(posedge clk); #1;
                bus.start = 1'b0;
                e = sb.pop_front();
                tests++;
                if (bus.out_valid !== 1'b1 || bus.c !== e.c || bus.out_last !== e.last)
                    begin fails++; $display("FAIL b2b%0d_beat%0d: vld=%b c=%h last=%b, want 1 %h %b",
                        op, k, bus.out_valid, bus.c, bus.out_last, e.c, e.last); end
                if (e.last) begin
                    tests++;
                    if (bus.borrow_out !== e.bout)
                        begin fails++; $display("FAIL b2b%0d_borrow: got %b want %b", op, bus.borrow_out, e.bout); end
`ifdef SUB_ZERO_FLAG_EN
                    tests++;
                    if (bus.eq !== e.eq)
                        begin fails++; $display("FAIL b2b%0d_eq: got %b want %b", op, bus.eq, e.eq); end
`endif
                end
            end
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
            tests++;
            if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0)
                begin fails++; $display("FAIL b2b%0d_drain: busy=%b vld=%b, want 0 0", op, bus.busy, bus.out_valid); end
        end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_patterns();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sub_chunked_seq.md
Name: sub_chunked_seq

Overview:
- Sequential N-bit subtractor, c = a - b. It is the inverse operation of the team's chunked sequential adder.
- Operands arrive least-significant W-bit chunk first, over CC beats. One output chunk is produced per accepted beat.
- A borrow register chains the beats. Valid/ready handshakes sit on both input and output, so the block can be dropped between chunk streamers in garbled-circuit netlist flows.

Parameters:
- N, 256, total operand width in bits.
- CC, 16, number of chunks (beats) per operation; N must be divisible by CC.
- W, N/CC (16), chunk width; derived, not overridable.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  pulse in IDLE to begin an operation.
- in_valid  input  1  a/b chunk present.
- in_ready  output  1  block accepts the chunk this cycle.
- a  input  W  minuend chunk.
- b  input  W  subtrahend chunk.
- c  output  W  difference chunk (registered).
- out_valid  output  1  c is valid.
- out_ready  input  1  downstream accepts c.
- out_last  output  1  c is the final (most-significant) chunk.
- borrow_out  output  1  final borrow (a < b, unsigned); meaningful only with out_last.
- busy  output  1  operation in progress (state != IDLE).

Behaviour:
- Reset (rst=0, async): state=IDLE, borrow=0, chunk counter=0, c=0, out_valid=0, out_last=0, borrow_out=0. in_ready=0 and busy=0 follow from state.
- FSM states: IDLE, RUN, DRAIN.
- IDLE -> RUN on start=1. Entering RUN clears borrow and counter. in_ready=0 in IDLE, so a chunk presented in the same cycle as start is not accepted.
- start is ignored in RUN and DRAIN.
- in_ready = (state==RUN) && (!out_valid || out_ready).
- Input accept (in_valid && in_ready):
  - c <= a - b - borrow, modulo 2^W.
  - borrow <= (a < b + borrow), evaluated at W+1 bits.
  - out_valid <= 1.
  - out_last <= (counter == CC-1).
  - counter increments.
  - Latency: 1 cycle, accept to out_valid.
- On the final accept (counter==CC-1): borrow_out <= computed borrow, state -> DRAIN, counter wraps to 0.
- Output transfer occurs on out_valid && out_ready. With no new accept in the same cycle, out_valid <= 0. A simultaneous accept and transfer keeps out_valid=1 and loads the new chunk (full throughput, 1 beat/cycle).
- While out_valid=1 and out_ready=0: c, out_last and borrow_out hold; in_ready=0.
- DRAIN -> IDLE when the last chunk transfers. out_last and out_valid clear.
- borrow_out holds its value until the next start.
- Reset mid-operation aborts immediately to the reset values. No partial result survives.
- CC=1 is legal: the first accept is also last.

Optional Feature:
- Macro: SUB_ZERO_FLAG_EN.
- Defined:
  - Adds output eq (1 bit, reset 0).
  - An internal flag is set to 1 on start and ANDed with (a-b-borrow == 0) on each accept.
  - eq presents the flag alongside out_last (eq = a==b over all N bits) and is 0 otherwise.
- Undefined: no eq port and no flag register. All other behaviour is identical.

Test Plan:
- Operands a=1, b=0, out_ready=1 -> chunk0 c=0x0001; chunks 1..15 c=0x0000; out_last only on beat 15; borrow_out=0.
- Operands a=0, b=1 -> every chunk c=0xFFFF; borrow_out=1 with out_last; eq=0 if SUB_ZERO_FLAG_EN is defined.
- Borrow ripple: a=2^16 (chunk1=1), b=1 (chunk0=1) -> chunk0 c=0xFFFF, chunk1 c=0x0000, the rest 0; borrow_out=0.
- Equal operands a=b=all chunks 0x8000 -> every c=0x0000, borrow_out=0; eq=1 with the macro.
- Backpressure: out_ready=0 for 3 cycles after the beat-4 accept -> in_ready=0, c holds its value, no beat lost or duplicated; the 16 beats complete afterwards.
- Reset: rst pulsed low after the chunk-7 accept -> out_valid=0, busy=0 immediately. The following start with a=5, b=3 yields chunk0 c=0x0002 and borrow_out=0.
